branch_predictor_table: RTL and testbench

- Parametrised branch direction predictor for the fetch stage; successor to the single 2-bit saturating counter predictor.
- Holds 2^LOG_ENTRY 2-bit saturating counters, indexed by PC (bimodal) or PC XOR global history (gshare).
- Keeps a speculatively updated global history register (GHR) and repairs it on mispredict.
- Predictions are registered (1-cycle latency); updates arrive from the branch-resolution stage.

---
 rtl/branch_predictor_table_pkg.sv | 23 ++
 rtl/branch_predictor_table_if.sv | 41 ++++
 rtl/branch_predictor_table_sat_counter2.sv | 28 ++
 rtl/branch_predictor_table.sv | 131 +++++++++++++
 tb/tb_branch_predictor_table.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_table_pkg.sv
// ---------------------------------------------------------------------------
// branch_predictor_table_pkg
// Shared definitions for the branch direction predictor.
//   - W_BRID          : width of a branch identifier tag
//   - cnt_e           : 2-bit saturating counter states
//   - MODE_BIMODAL/MODE_GSHARE : index formation modes
// No ports (package).
// ---------------------------------------------------------------------------
package branch_predictor_table_pkg;

   localparam int W_BRID = 2;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } cnt_e;

   localparam int MODE_BIMODAL = 0;
   localparam int MODE_GSHARE  = 1;

endpackage

// File: rtl/branch_predictor_table_if.sv
// ---------------------------------------------------------------------------
// branch_predictor_table_if
// Bundles the prediction request/response and the resolution update
// signals of the branch predictor.
//   master : fetch / resolution side (drives *_i, observes *_o)
//   slave  : the predictor table      (observes *_i, drives *_o)
// Parameters must match those of the predictor instance it connects to.
// ---------------------------------------------------------------------------
interface branch_predictor_table_if #(
   parameter int W_PC      = 32,
   parameter int LOG_ENTRY = 6,
   parameter int W_GHR     = 6
) ();

   logic                 pred_v_i;
   logic [W_PC-1:0]      pred_pc_i;
   logic                 pred_v_o;
   logic                 pred_taken_o;
   logic [1:0]           pred_cnt_o;
   logic [LOG_ENTRY-1:0] pred_idx_o;
   logic [W_GHR-1:0]     pred_ghr_o;

   logic                 upd_v_i;
   logic [LOG_ENTRY-1:0] upd_idx_i;
   logic                 upd_taken_i;
   logic                 upd_miss_i;
   logic [W_GHR-1:0]     upd_ghr_i;

   modport master (
      output pred_v_i, pred_pc_i,
      output upd_v_i, upd_idx_i, upd_taken_i, upd_miss_i, upd_ghr_i,
      input  pred_v_o, pred_taken_o, pred_cnt_o, pred_idx_o, pred_ghr_o
   );

   modport slave (
      input  pred_v_i, pred_pc_i,
      input  upd_v_i, upd_idx_i, upd_taken_i, upd_miss_i, upd_ghr_i,
      output pred_v_o, pred_taken_o, pred_cnt_o, pred_idx_o, pred_ghr_o
   );

endinterface

// File: rtl/branch_predictor_table_sat_counter2.sv
// ---------------------------------------------------------------------------
// sat_counter2
// Combinational next-state function of a 2-bit saturating counter.
//   cnt_i   : current counter value
//   taken_i : branch outcome (1 = count up, 0 = count down)
//   cnt_o   : next counter value, clamped to [0,3]
// ---------------------------------------------------------------------------
module sat_counter2
   import branch_predictor_table_pkg::*;
(
   input  logic [1:0] cnt_i,
   input  logic       taken_i,
   output logic [1:0] cnt_o
);

   // Step toward the outcome, holding at the strong end states.
   always_comb begin
      cnt_o = cnt_i;
      if (taken_i) begin
         if (cnt_i != ST) begin
            cnt_o = cnt_i + 2'd1;
         end
      end else if (cnt_i != SNT) begin
         cnt_o = cnt_i - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor_table.sv
// ---------------------------------------------------------------------------
// branch_predictor_table
// Bimodal / gshare branch direction predictor built from 2^LOG_ENTRY
// 2-bit saturating counters plus a speculative global history register.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-low reset
//   bus   : branch_predictor_table_if.slave
//           pred_v_i/pred_pc_i request a prediction; one cycle later
//           pred_v_o, pred_taken_o, pred_cnt_o, pred_idx_o, pred_ghr_o.
//           upd_v_i/upd_idx_i/upd_taken_i train a counter; upd_miss_i with
//           upd_ghr_i repairs the history after a mispredict.
// ---------------------------------------------------------------------------
module branch_predictor_table
   import branch_predictor_table_pkg::*;
#(
   parameter int         W_PC      = 32,
   parameter int         LOG_ENTRY = 6,
   parameter int         W_GHR     = 6,
   parameter int         MODE      = MODE_GSHARE,
   parameter logic [1:0] INIT_CNT  = 2'b11
) (
   input  logic                    clk,
   input  logic                    reset,
   branch_predictor_table_if.slave bus
);

   localparam int ENTRIES = 1 << LOG_ENTRY;

   logic [1:0]           table_q [ENTRIES];
   logic [W_GHR-1:0]     ghr_q;

   logic [LOG_ENTRY-1:0] pc_idx;
   logic [LOG_ENTRY-1:0] rd_idx;
   logic [1:0]           rd_cnt_raw;
   logic [1:0]           rd_cnt;
   logic [1:0]           byp_next;
   logic [1:0]           upd_cur;
   logic [1:0]           upd_next;
   logic                 rd_bypass;
   logic                 repair;

   logic                 pred_v_q;
   logic [1:0]           pred_cnt_q;
   logic [LOG_ENTRY-1:0] pred_idx_q;
   logic [W_GHR-1:0]     pred_ghr_q;

   logic                 unused_pc;

   // PC bits above the index and the byte offset never reach the table.
   assign unused_pc = ^{bus.pred_pc_i[W_PC-1:LOG_ENTRY+2], bus.pred_pc_i[1:0]};

   assign pc_idx = bus.pred_pc_i[LOG_ENTRY+1:2];

   generate
      if (MODE == MODE_GSHARE) begin : g_gshare
         assign rd_idx = pc_idx ^ LOG_ENTRY'(ghr_q);
      end else begin : g_bimodal
         assign rd_idx = pc_idx;
      end
   endgenerate

   assign upd_cur    = table_q[bus.upd_idx_i];
   assign rd_cnt_raw = table_q[rd_idx];

   sat_counter2 u_upd_cnt (
      .cnt_i   (upd_cur),
      .taken_i (bus.upd_taken_i),
      .cnt_o   (upd_next)
   );

   // Same next-state function applied to the read entry, so a same-cycle
   // update to that entry is visible to the prediction without a second
   // read port on the write side.
   sat_counter2 u_byp_cnt (
      .cnt_i   (rd_cnt_raw),
      .taken_i (bus.upd_taken_i),
      .cnt_o   (byp_next)
   );

   assign rd_bypass = bus.upd_v_i && (bus.upd_idx_i == rd_idx);
   assign rd_cnt    = rd_bypass ? byp_next : rd_cnt_raw;
   assign repair    = bus.upd_v_i && bus.upd_miss_i;

   // Counter table: flop array so reset can load every entry at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            table_q[i] <= INIT_CNT;
         end
      end else if (bus.upd_v_i) begin
         table_q[bus.upd_idx_i] <= upd_next;
      end
   end

   // History: a repair wins over the speculative shift because the
   // same-cycle fetch is on the flushed path.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ghr_q <= '0;
      end else if (repair) begin
         ghr_q <= {bus.upd_ghr_i[W_GHR-2:0], bus.upd_taken_i};
      end else if (bus.pred_v_i) begin
         ghr_q <= {ghr_q[W_GHR-2:0], rd_cnt[1]};
      end
   end

   // Registered prediction; payload holds its value between requests.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pred_v_q   <= 1'b0;
         pred_cnt_q <= 2'b00;
         pred_idx_q <= '0;
         pred_ghr_q <= '0;
      end else begin
         pred_v_q <= bus.pred_v_i;
         if (bus.pred_v_i) begin
            pred_cnt_q <= rd_cnt;
            pred_idx_q <= rd_idx;
            pred_ghr_q <= ghr_q;
         end
      end
   end

   assign bus.pred_v_o     = pred_v_q;
   assign bus.pred_cnt_o   = pred_cnt_q;
   assign bus.pred_taken_o = pred_cnt_q[1];
   assign bus.pred_idx_o   = pred_idx_q;
   assign bus.pred_ghr_o   = pred_ghr_q;

endmodule

// File: tb/tb_branch_predictor_table.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor_table
// Self-checking bench for branch_predictor_table in gshare mode, with a
// behavioural model of the counter table and global history.
// ---------------------------------------------------------------------------
module tb_branch_predictor_table;

   localparam int W_PC      = 32;
   localparam int LOG_ENTRY = 6;
   localparam int W_GHR     = 6;
   localparam int ENTRIES   = 64;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   int errors = 0;
   int checks = 0;

   int m_cnt [ENTRIES];
   int m_ghr;
   int exp_v, exp_taken, exp_cnt, exp_idx, exp_ghr;
   bit compare_en = 1'b0;

   int dec_exp [4] = '{2, 1, 0, 0};
   int inc_exp [4] = '{1, 2, 3, 3};

   always #5 clk = ~clk;

   branch_predictor_table_if #(
      .W_PC      (W_PC),
      .LOG_ENTRY (LOG_ENTRY),
      .W_GHR     (W_GHR)
   ) bus ();

   branch_predictor_table #(
      .W_PC      (W_PC),
      .LOG_ENTRY (LOG_ENTRY),
      .W_GHR     (W_GHR),
      .MODE      (1),
      .INIT_CNT  (2'b11)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Comparison helper shared by the model compare and literal checks.
   task automatic check_output(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic int sat(input int c, input bit t);
      if (t) return (c >= 3) ? 3 : c + 1;
      else   return (c <= 0) ? 0 : c - 1;
   endfunction

   function automatic int model_index(input int unsigned pc);
      return int'((pc >> 2) & 32'd63) ^ m_ghr;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < ENTRIES; i++) m_cnt[i] = 3;
      m_ghr     = 0;
      exp_v     = 0;
      exp_taken = 0;
      exp_cnt   = 0;
      exp_idx   = 0;
      exp_ghr   = 0;
   endtask

   // Drive one cycle of inputs at the falling edge and advance the model.
   task automatic apply_stimulus(input bit pv, input int unsigned pc, input bit uv,
                                 input int uidx, input bit ut, input bit um, input int ughr);
      int idx, c;
      @(negedge clk);
      bus.pred_v_i    = pv;
      bus.pred_pc_i   = pc;
      bus.upd_v_i     = uv;
      bus.upd_idx_i   = uidx[LOG_ENTRY-1:0];
      bus.upd_taken_i = ut;
      bus.upd_miss_i  = um;
      bus.upd_ghr_i   = ughr[W_GHR-1:0];
      idx = model_index(pc);
      c   = m_cnt[idx];
      if (uv && uidx == idx) c = sat(c, ut);
      if (pv) begin
         exp_v     = 1;
         exp_cnt   = c;
         exp_taken = (c >= 2) ? 1 : 0;
         exp_idx   = idx;
         exp_ghr   = m_ghr;
      end else begin
         exp_v = 0;
      end
      if (uv) m_cnt[uidx] = sat(m_cnt[uidx], ut);
      if (uv && um)   m_ghr = ((ughr << 1) | int'(ut)) & 63;
      else if (pv)    m_ghr = ((m_ghr << 1) | ((c >= 2) ? 1 : 0)) & 63;
   endtask

   task automatic idle();
      apply_stimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0);
   endtask

   task automatic predict_idx(input int idx, input bit uv, input int uidx, input bit ut);
      apply_stimulus(1'b1, 32'((idx ^ m_ghr) & 63) << 2, uv, uidx, ut, 1'b0, 0);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      bus.pred_v_i = 1'b0;
      bus.upd_v_i  = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   // Model comparison on every cycle, sampled just after the rising edge.
   always begin
      @(posedge clk);
      #1;
      if (compare_en) begin
         check_output("pred_v_o",     int'(bus.pred_v_o),     exp_v);
         check_output("pred_taken_o", int'(bus.pred_taken_o), exp_taken);
         check_output("pred_cnt_o",   int'(bus.pred_cnt_o),   exp_cnt);
         check_output("pred_idx_o",   int'(bus.pred_idx_o),   exp_idx);
         check_output("pred_ghr_o",   int'(bus.pred_ghr_o),   exp_ghr);
      end
   end

   initial begin
      int unsigned pc;
      int          uidx;
      bus.pred_v_i    = 1'b0;
      bus.pred_pc_i   = '0;
      bus.upd_v_i     = 1'b0;
      bus.upd_idx_i   = '0;
      bus.upd_taken_i = 1'b0;
      bus.upd_miss_i  = 1'b0;
      bus.upd_ghr_i   = '0;
      model_reset();

      #2 reset = 1'b0;
      #1;
      check_output("reset_pred_v",   int'(bus.pred_v_o),   0);
      check_output("reset_pred_cnt", int'(bus.pred_cnt_o), 0);
      check_output("reset_pred_ghr", int'(bus.pred_ghr_o), 0);
      compare_en = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // First prediction after reset: strongly taken, history empty.
      apply_stimulus(1'b1, 32'h40, 1'b0, 0, 1'b0, 1'b0, 0);
      settle();
      check_output("first_v",     int'(bus.pred_v_o),     1);
      check_output("first_cnt",   int'(bus.pred_cnt_o),   3);
      check_output("first_taken", int'(bus.pred_taken_o), 1);
      check_output("first_ghr",   int'(bus.pred_ghr_o),   0);
      check_output("first_idx",   int'(bus.pred_idx_o),   16);

      apply_stimulus(1'b1, 32'h0, 1'b0, 0, 1'b0, 1'b0, 0);
      settle();
      check_output("ghr_after_one", int'(bus.pred_ghr_o), 1);

      // History is now 0b000011: raw index 16 becomes 19.
      apply_stimulus(1'b1, 32'h40, 1'b0, 0, 1'b0, 1'b0, 0);
      settle();
      check_output("gshare_idx", int'(bus.pred_idx_o), 19);

      for (int k = 0; k < 4; k++) begin
         apply_stimulus(1'b0, 0, 1'b1, 5, 1'b0, 1'b0, 0);
         predict_idx(5, 1'b0, 0, 1'b0);
         settle();
         check_output("dec_cnt", int'(bus.pred_cnt_o), dec_exp[k]);
      end
      check_output("dec_taken", int'(bus.pred_taken_o), 0);

      for (int k = 0; k < 4; k++) begin
         apply_stimulus(1'b0, 0, 1'b1, 5, 1'b1, 1'b0, 0);
         predict_idx(5, 1'b0, 0, 1'b0);
         settle();
         check_output("inc_cnt", int'(bus.pred_cnt_o), inc_exp[k]);
      end

      // Entry 7 to weakly taken, then same-cycle update and read.
      apply_stimulus(1'b0, 0, 1'b1, 7, 1'b0, 1'b0, 0);
      predict_idx(7, 1'b1, 7, 1'b0);
      settle();
      check_output("bypass_cnt",   int'(bus.pred_cnt_o),   1);
      check_output("bypass_taken", int'(bus.pred_taken_o), 0);

      // Repair alongside a prediction: history rebuilt, shift dropped.
      apply_stimulus(1'b1, 32'h80, 1'b1, 3, 1'b1, 1'b1, 6'b101010);
      settle();
      check_output("repair_pred_v", int'(bus.pred_v_o), 1);
      apply_stimulus(1'b1, 32'h0, 1'b0, 0, 1'b0, 1'b0, 0);
      settle();
      check_output("repair_ghr", int'(bus.pred_ghr_o), 21);

      // Asynchronous reset while a prediction is in flight.
      apply_stimulus(1'b1, 32'h1234, 1'b1, 9, 1'b0, 1'b0, 0);
      #2;
      reset = 1'b0;
      bus.pred_v_i = 1'b0;
      bus.upd_v_i  = 1'b0;
      model_reset();
      #1;
      check_output("async_reset_v",   int'(bus.pred_v_o),   0);
      check_output("async_reset_idx", int'(bus.pred_idx_o), 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      for (int n = 0; n < 600; n++) begin
         pc   = $urandom;
         uidx = ($urandom_range(0, 1) == 1) ? model_index(pc) : int'($urandom_range(0, 63));
         apply_stimulus($urandom_range(0, 1) == 1, pc, $urandom_range(0, 1) == 1, uidx,
                        $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                        int'($urandom_range(0, 63)));
         if (n == 300) do_reset();
      end

      idle();
      @(posedge clk);
      #3;
      compare_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
